fetch_queue_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the single-cycle decode/execute datapath.
- Owns the word-addressed fetch PC and issues one read per cycle to instruction memory (fixed 1-cycle read latency).
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts redirects (j, jal, jr, taken branch) resolved downstream, flushing stale instructions, including the one in flight.

---
 rtl/fetch_queue_unit_pkg.sv | 22 ++
 rtl/fetch_queue_unit_if.sv | 23 ++
 rtl/fetch_queue_unit_fifo.sv | 59 +++++
 rtl/fetch_queue_unit.sv | 98 +++++++++
 tb/tb_fetch_queue_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage and its decode neighbour.
package fetch_queue_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'd0;

    // Decode uses these to recognise redirecting instructions
    localparam logic [5:0] OP_J   = 6'd2;
    localparam logic [5:0] OP_JAL = 6'd3;
    localparam logic [5:0] FN_JR  = 6'd8;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } queue_entry_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FULL  = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Instruction-memory, redirect and decode handshake signals of the fetch stage.
interface fetch_queue_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_link;
    logic        inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, inst_link,
        input  imem_rdata, redirect_valid, redirect_target, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, inst_link,
        output imem_rdata, redirect_valid, redirect_target, inst_ready
    );
endinterface

// File: rtl/fetch_queue_unit_fifo.sv
// Circular instruction queue with push/pop/clear; head entry is visible combinationally.
module fetch_fifo
    import fetch_queue_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    push,
    input  queue_entry_t            push_data,
    input  logic                    pop,
    output queue_entry_t            head,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wptr_reg;
    logic [AW-1:0] rptr_reg;
    logic [CW-1:0] count_reg;
    queue_entry_t  entries [DEPTH];

    // Storage is reset so the head reads as zero straight out of reset
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            queue_entry_t entry_reg;
            always_ff @(posedge clock or posedge reset) begin
                if (reset)
                    entry_reg <= '0;
                else if (push && !clear && wptr_reg == AW'(gi))
                    entry_reg <= push_data;
            end
            assign entries[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else if (clear) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push)
                wptr_reg <= wptr_reg + AW'(1);
            if (pop)
                rptr_reg <= rptr_reg + AW'(1);
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    assign head  = entries[rptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the word PC, issues credit-limited imem reads and queues results for decode.
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    fetch_queue_unit_if.master  bus
);
    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_reg;
    logic [31:0]   pc_q_reg;
    logic          inflight_reg;
    logic          kill_reg;
    fetch_state_t  state_reg;
    fetch_state_t  state_next;

    logic          push;
    logic          pop;
    logic          issue;
    logic [CW-1:0] count;
    logic [CW:0]   credit_used;
    logic [CW:0]   count_next;
    queue_entry_t  head;
    queue_entry_t  push_data;

    assign pop       = bus.inst_valid && bus.inst_ready;
    // A redirect also drops the response arriving in its own cycle
    assign push      = inflight_reg && !kill_reg && !bus.redirect_valid;
    assign push_data = '{inst: bus.imem_rdata, pc: pc_q_reg};

    // The in-flight read already owns a slot; a same-cycle dequeue frees one
    assign credit_used = {1'b0, count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, inflight_reg};
    assign issue       = !reset && !bus.redirect_valid && (credit_used < DEPTH_C);
    assign count_next  = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (bus.redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_comb begin
        state_next = state_reg;
        if (bus.redirect_valid) begin
            state_next = ST_FLUSH;
        end else begin
            case (state_reg)
                ST_RUN:   if (count_next == DEPTH_C) state_next = ST_FULL;
                ST_FULL:  if (pop) state_next = ST_RUN;
                ST_FLUSH: state_next = ST_RUN;
                default:  state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_reg <= RESET_PC;
            pc_q_reg     <= '0;
            inflight_reg <= 1'b0;
            kill_reg     <= 1'b0;
            state_reg    <= ST_RUN;
        end else begin
            state_reg <= state_next;
            if (bus.redirect_valid) begin
                fetch_pc_reg <= bus.redirect_target;
                inflight_reg <= 1'b0;
                kill_reg     <= inflight_reg;
            end else begin
                // kill lives for the single flush cycle only
                kill_reg     <= 1'b0;
                inflight_reg <= issue;
                if (issue) begin
                    pc_q_reg     <= fetch_pc_reg;
                    fetch_pc_reg <= fetch_pc_reg + 32'd1;
                end
            end
        end
    end

    assign bus.imem_req   = issue;
    assign bus.imem_addr  = fetch_pc_reg;
    assign bus.inst_valid = (count != '0) && (state_reg != ST_FLUSH);
    assign bus.inst       = head.inst;
    assign bus.inst_pc    = head.pc;
    assign bus.inst_link  = head.pc + 32'd1;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: directed vector table, async-reset sequence, random stream model.
module tb_fetch_queue_unit;
    import fetch_queue_unit_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    typedef struct {
        logic         rst;
        logic         ready;
        logic         redir;
        logic [31:0]  target;
        logic         exp_req;
        logic [31:0]  exp_addr;
        logic         exp_valid;
        logic [31:0]  exp_pc;
        logic         chk_st;
        fetch_state_t exp_st;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    fetch_queue_unit_if bus();

    fetch_queue_unit #(.DEPTH(2), .RESET_PC(32'd0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Instruction memory: 1-cycle latency, word = address ^ KEY
    always @(posedge clock or posedge reset) begin
        if (reset)
            bus.imem_rdata <= 32'hDEAD_BEEF;
        else if (bus.imem_req)
            bus.imem_rdata <= bus.imem_addr ^ KEY;
        else
            bus.imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 32'd0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic vec_t mk(logic rst, logic rdy, logic rd, logic [31:0] tg,
                                logic rq, logic [31:0] ad, logic vl, logic [31:0] pc,
                                logic cs, fetch_state_t st);
        vec_t v;
        v.rst = rst;  v.ready = rdy;  v.redir = rd;  v.target = tg;
        v.exp_req = rq;  v.exp_addr = ad;  v.exp_valid = vl;  v.exp_pc = pc;
        v.chk_st = cs;  v.exp_st = st;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        if (v.rst)
            do_reset();
        bus.inst_ready      = v.ready;
        bus.redirect_valid  = v.redir;
        bus.redirect_target = v.target;
        #1;
        check($sformatf("v%0d_req", idx), {31'd0, bus.imem_req}, {31'd0, v.exp_req});
        check($sformatf("v%0d_addr", idx), bus.imem_addr, v.exp_addr);
        check($sformatf("v%0d_valid", idx), {31'd0, bus.inst_valid}, {31'd0, v.exp_valid});
        if (v.exp_valid) begin
            check($sformatf("v%0d_pc", idx), bus.inst_pc, v.exp_pc);
            check($sformatf("v%0d_inst", idx), bus.inst, v.exp_pc ^ KEY);
            check($sformatf("v%0d_link", idx), bus.inst_link, v.exp_pc + 32'd1);
        end
        if (v.chk_st)
            check($sformatf("v%0d_state", idx), {30'd0, dut.state_reg}, {30'd0, v.exp_st});
        @(posedge clock);
        @(negedge clock);
    endtask

    vec_t tbl[$];

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic        rv;
        logic        rdy;
        int          grace;

        bus.inst_ready      = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'd0;

        // Reset release with decode always ready
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, ST_RUN));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0, ST_RUN));
        tbl.push_back(mk(0, 1, 0, 0, 1, 2, 1, 0, 0, ST_RUN));
        tbl.push_back(mk(0, 1, 0, 0, 1, 3, 1, 1, 0, ST_RUN));
        tbl.push_back(mk(0, 1, 0, 0, 1, 4, 1, 2, 0, ST_RUN));
        // Backpressure for 6 cycles, then drain
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 1, ST_RUN));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, ST_RUN));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 1, ST_RUN));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 1, ST_FULL));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 1, ST_FULL));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 1, ST_FULL));
        tbl.push_back(mk(0, 1, 0, 0, 1, 2, 1, 0, 1, ST_FULL));
        tbl.push_back(mk(0, 1, 0, 0, 1, 3, 1, 1, 1, ST_RUN));
        tbl.push_back(mk(0, 1, 0, 0, 1, 4, 1, 2, 0, ST_RUN));
        // Redirect to 100 while the read of address 4 is in flight
        tbl.push_back(mk(0, 0, 1, 100, 0, 5, 1, 3, 0, ST_RUN));
        tbl.push_back(mk(0, 1, 0, 0, 1, 100, 0, 0, 1, ST_FLUSH));
        tbl.push_back(mk(0, 1, 0, 0, 1, 101, 0, 0, 1, ST_RUN));
        tbl.push_back(mk(0, 1, 0, 0, 1, 102, 1, 100, 0, ST_RUN));
        tbl.push_back(mk(0, 1, 0, 0, 1, 103, 1, 101, 0, ST_RUN));
        // Redirect together with a dequeue of pc 102
        tbl.push_back(mk(0, 1, 1, 200, 0, 104, 1, 102, 0, ST_RUN));
        tbl.push_back(mk(0, 1, 0, 0, 1, 200, 0, 0, 0, ST_RUN));
        tbl.push_back(mk(0, 1, 0, 0, 1, 201, 0, 0, 0, ST_RUN));
        tbl.push_back(mk(0, 1, 0, 0, 1, 202, 1, 200, 0, ST_RUN));
        // PC wrap-around
        tbl.push_back(mk(0, 1, 1, 32'hFFFF_FFFF, 0, 203, 1, 201, 0, ST_RUN));
        tbl.push_back(mk(0, 1, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, ST_RUN));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, ST_RUN));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1, 32'hFFFF_FFFF, 0, ST_RUN));
        tbl.push_back(mk(0, 1, 0, 0, 1, 2, 1, 0, 0, ST_RUN));
        tbl.push_back(mk(0, 1, 0, 0, 1, 3, 1, 1, 0, ST_RUN));

        foreach (tbl[i])
            run_vec(tbl[i], i);

        // Async reset asserted during the flush cycle after a redirect with one entry queued
        run_vec(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, ST_RUN), 100);
        run_vec(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, ST_RUN), 101);
        run_vec(mk(0, 0, 1, 32'h55, 0, 2, 1, 0, 0, ST_RUN), 102);
        bus.redirect_valid = 1'b0;
        #1;
        check("flush_state", {30'd0, dut.state_reg}, {30'd0, ST_FLUSH});
        check("flush_addr", bus.imem_addr, 32'h55);
        #1;
        reset = 1'b1;
        #1;
        check("async_req", {31'd0, bus.imem_req}, 32'd0);
        check("async_addr", bus.imem_addr, 32'd0);
        check("async_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("async_inst", bus.inst, 32'd0);
        check("async_pc", bus.inst_pc, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        run_vec(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, ST_RUN), 103);
        run_vec(mk(0, 1, 0, 0, 1, 1, 0, 0, 0, ST_RUN), 104);
        run_vec(mk(0, 1, 0, 0, 1, 2, 1, 0, 0, ST_RUN), 105);

        // Random stream: decode must see consecutive pcs from the last restart point,
        // invalid exactly for the two cycles after reset or a redirect, valid otherwise
        do_reset();
        exp_pc = 32'd0;
        grace  = 2;
        for (int c = 0; c < 3000; c++) begin
            rdy = ($urandom_range(3) != 0);
            rv  = ($urandom_range(15) == 0);
            tgt = ($urandom_range(1) == 1) ? $urandom : (32'hFFFF_FFFF - 32'($urandom_range(3)));
            bus.inst_ready      = rdy;
            bus.redirect_valid  = rv;
            bus.redirect_target = tgt;
            #1;
            check($sformatf("r%0d_valid", c), {31'd0, bus.inst_valid}, {31'd0, (grace == 0)});
            if (bus.inst_valid) begin
                check($sformatf("r%0d_pc", c), bus.inst_pc, exp_pc);
                check($sformatf("r%0d_inst", c), bus.inst, exp_pc ^ KEY);
                check($sformatf("r%0d_link", c), bus.inst_link, exp_pc + 32'd1);
            end
            if (rv)
                check($sformatf("r%0d_req_redir", c), {31'd0, bus.imem_req}, 32'd0);
            if (bus.inst_valid && rdy)
                exp_pc = exp_pc + 32'd1;
            if (rv) begin
                exp_pc = tgt;
                grace  = 2;
            end else if (grace > 0) begin
                grace--;
            end
            @(posedge clock);
            @(negedge clock);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
